// File: rtl/bit_packer_pkg.sv
// Shared types and default sizing for the serial-to-parallel bit packer.
package bit_packer_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } pk_state_t;
endpackage

// File: rtl/bit_packer_if.sv
// Serial bit input, word output handshake and status bundle of the bit packer.
import bit_packer_pkg::*;

interface bit_packer_if #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
);
    logic             bit_in;
    logic             bit_valid;
    logic             sync_clr;
    logic             ovf_clr;
    logic             word_ready;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             overflow;
    logic [CNT_W-1:0] word_count;

    modport master (
        output bit_in, bit_valid, sync_clr, ovf_clr, word_ready,
        input  word_out, word_valid, overflow, word_count
    );

    modport slave (
        input  bit_in, bit_valid, sync_clr, ovf_clr, word_ready,
        output word_out, word_valid, overflow, word_count
    );
endinterface

// File: rtl/bit_packer_fifo.sv
// 2-entry head/tail FIFO; data reads 0 when empty. Latency 1 from push to data.
// Push into full is accepted only with a same-cycle pop, otherwise ignored.
import bit_packer_pkg::*;

module bit_packer_fifo #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] data
);
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [1:0]       cnt_q;
    logic             do_pop;
    logic             do_push;

    assign full    = (cnt_q == 2'd2);
    assign empty   = (cnt_q == 2'd0);
    assign data    = empty ? '0 : head_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (cnt_q == 2'd0) head_q <= din;
                    else               tail_q <= din;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    // occupancy unchanged; a single entry is simply replaced
                    if (cnt_q == 2'd1) begin
                        head_q <= din;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= din;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/bit_packer.sv
// Packs MSB-first serial bits into WIDTH-bit words queued in a 2-entry FIFO.
// Latency 1 cycle from last bit to word_valid. word_ready backpressures; a full FIFO drops and flags overflow.
import bit_packer_pkg::*;

module bit_packer #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input logic         clk,
    input logic         reset,
    bit_packer_if.slave bus
);
    localparam int BC_W = $clog2(WIDTH);

    pk_state_t        state;
    logic [BC_W-1:0]  bit_cnt;
    logic [WIDTH-1:0] shift_q;
    logic [CNT_W-1:0] count_q;
    logic             ovf_q;
    logic             last_bit;
    logic             pop;
    logic             push_ok;
    logic             drop;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] word_nxt;
    logic [WIDTH-1:0] fifo_data;

    assign word_nxt = {shift_q[WIDTH-2:0], bus.bit_in};
    assign last_bit = bus.bit_valid && (state == FILL) && (bit_cnt == BC_W'(WIDTH-1));
    assign pop      = !empty && bus.word_ready;
    assign push_ok  = last_bit && (!full || pop);
    assign drop     = last_bit && full && !pop;

    bit_packer_fifo #(.WIDTH(WIDTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (last_bit),
        .pop   (pop),
        .din   (word_nxt),
        .full  (full),
        .empty (empty),
        .data  (fifo_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            // a completing bit wins over sync_clr so the finished word is kept
            if (last_bit) begin
                state   <= IDLE;
                bit_cnt <= '0;
                shift_q <= '0;
            end else if (bus.sync_clr) begin
                if (bus.bit_valid) begin
                    state   <= FILL;
                    bit_cnt <= BC_W'(1);
                    shift_q <= WIDTH'(bus.bit_in);
                end else begin
                    state   <= IDLE;
                    bit_cnt <= '0;
                    shift_q <= '0;
                end
            end else if (bus.bit_valid) begin
                state   <= FILL;
                bit_cnt <= bit_cnt + 1'b1;
                shift_q <= word_nxt;
            end

            if (push_ok) count_q <= count_q + 1'b1;

            if (drop)             ovf_q <= 1'b1;
            else if (bus.ovf_clr) ovf_q <= 1'b0;
        end
    end

    assign bus.word_out   = fifo_data;
    assign bus.word_valid = !empty;
    assign bus.overflow   = ovf_q;
    assign bus.word_count = count_q;
endmodule

// File: tb/tb_bit_packer.sv
// Directed-vector bench for bit_packer (WIDTH=8, CNT_W=8) with hand-computed expectations.
module tb_bit_packer;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    bit_packer_if #(.WIDTH(8), .CNT_W(8)) bus ();

    bit_packer #(.WIDTH(8), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // send n bits of w, starting at MSB-first position 'first'
    task automatic send_bits(input logic [7:0] w, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            bus.bit_in    = w[7-i];
            bus.bit_valid = 1'b1;
            tick();
        end
        bus.bit_valid = 1'b0;
    endtask

    task automatic do_reset();
        bus.bit_valid  = 1'b0;
        bus.bit_in     = 1'b0;
        bus.sync_clr   = 1'b0;
        bus.ovf_clr    = 1'b0;
        bus.word_ready = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset          = 1'b0;
        bus.bit_in     = 1'b0;
        bus.bit_valid  = 1'b0;
        bus.sync_clr   = 1'b0;
        bus.ovf_clr    = 1'b0;
        bus.word_ready = 1'b0;
        #1;
        chk("rst_valid", 32'(bus.word_valid), 32'd0);
        chk("rst_out",   32'(bus.word_out),   32'h00);
        chk("rst_ovf",   32'(bus.overflow),   32'd0);
        chk("rst_cnt",   32'(bus.word_count), 32'd0);
        do_reset();

        // back-to-back bits with downstream ready
        bus.word_ready = 1'b1;
        send_bits(8'hB2, 0, 7);
        chk("b2_early_valid", 32'(bus.word_valid), 32'd0);
        send_bits(8'hB2, 7, 1);
        chk("b2_valid", 32'(bus.word_valid), 32'd1);
        chk("b2_out",   32'(bus.word_out),   32'hB2);
        chk("b2_cnt",   32'(bus.word_count), 32'd1);
        tick();
        chk("b2_popped", 32'(bus.word_valid), 32'd0);

        // same word with 3-cycle idle gaps
        for (int i = 0; i < 8; i++) begin
            send_bits(8'hB2, i, 1);
            if (i < 7) begin
                repeat (3) tick();
                chk("gap_no_valid", 32'(bus.word_valid), 32'd0);
            end
        end
        chk("gap_valid", 32'(bus.word_valid), 32'd1);
        chk("gap_out",   32'(bus.word_out),   32'hB2);
        chk("gap_cnt",   32'(bus.word_count), 32'd2);
        tick();
        chk("gap_popped", 32'(bus.word_valid), 32'd0);

        // overflow with stalled downstream
        do_reset();
        send_bits(8'h01, 0, 8);
        send_bits(8'h02, 0, 8);
        send_bits(8'h03, 0, 8);
        chk("ovf_out",  32'(bus.word_out),   32'h01);
        chk("ovf_flag", 32'(bus.overflow),   32'd1);
        chk("ovf_cnt",  32'(bus.word_count), 32'd2);
        tick();
        chk("ovf_stable", 32'(bus.word_out), 32'h01);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(bus.overflow), 32'd0);
        bus.word_ready = 1'b1;
        tick();
        chk("ovf_pop2", 32'(bus.word_out), 32'h02);
        tick();
        chk("ovf_drained", 32'(bus.word_valid), 32'd0);
        bus.word_ready = 1'b0;

        // drop on the same cycle as ovf_clr keeps the flag set
        send_bits(8'h10, 0, 8);
        send_bits(8'h20, 0, 8);
        send_bits(8'h30, 0, 7);
        bus.ovf_clr = 1'b1;
        send_bits(8'h30, 7, 1);
        bus.ovf_clr = 1'b0;
        chk("setwin_ovf", 32'(bus.overflow),   32'd1);
        chk("setwin_cnt", 32'(bus.word_count), 32'd4);
        chk("setwin_out", 32'(bus.word_out),   32'h10);

        // full FIFO, third word completes with a simultaneous pop
        do_reset();
        send_bits(8'h11, 0, 8);
        send_bits(8'h22, 0, 8);
        send_bits(8'h33, 0, 7);
        bus.word_ready = 1'b1;
        send_bits(8'h33, 7, 1);
        chk("full_pop_ovf", 32'(bus.overflow),   32'd0);
        chk("full_pop_cnt", 32'(bus.word_count), 32'd3);
        chk("full_pop_out", 32'(bus.word_out),   32'h22);
        tick();
        chk("full_pop_out3", 32'(bus.word_out), 32'h33);
        tick();
        chk("full_pop_empty", 32'(bus.word_valid), 32'd0);
        bus.word_ready = 1'b0;

        // sync_clr with a valid bit restarts the word
        do_reset();
        send_bits(8'hF8, 0, 5);
        bus.sync_clr = 1'b1;
        send_bits(8'h80, 0, 1);
        bus.sync_clr = 1'b0;
        chk("sclr_partial", 32'(bus.word_valid), 32'd0);
        send_bits(8'h80, 1, 6);
        chk("sclr_partial2", 32'(bus.word_valid), 32'd0);
        send_bits(8'h80, 7, 1);
        chk("sclr_out", 32'(bus.word_out),   32'h80);
        chk("sclr_cnt", 32'(bus.word_count), 32'd1);

        // sync_clr alone discards held bits
        do_reset();
        send_bits(8'hFF, 0, 3);
        bus.sync_clr = 1'b1;
        tick();
        bus.sync_clr = 1'b0;
        send_bits(8'h5A, 0, 8);
        chk("sclr_only_out", 32'(bus.word_out),   32'h5A);
        chk("sclr_only_cnt", 32'(bus.word_count), 32'd1);

        // sync_clr on the completing bit still pushes it
        do_reset();
        send_bits(8'hA5, 0, 7);
        bus.sync_clr = 1'b1;
        send_bits(8'hA5, 7, 1);
        bus.sync_clr = 1'b0;
        chk("sclr_last_out", 32'(bus.word_out),   32'hA5);
        chk("sclr_last_cnt", 32'(bus.word_count), 32'd1);
        send_bits(8'h3C, 0, 8);
        chk("sclr_next_cnt", 32'(bus.word_count), 32'd2);
        bus.word_ready = 1'b1;
        tick();
        chk("sclr_next_out", 32'(bus.word_out), 32'h3C);
        tick();
        chk("sclr_next_empty", 32'(bus.word_valid), 32'd0);
        bus.word_ready = 1'b0;

        // asynchronous reset between edges with data in flight
        do_reset();
        send_bits(8'h77, 0, 8);
        send_bits(8'hE0, 0, 3);
        chk("pre_arst_valid", 32'(bus.word_valid), 32'd1);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.word_valid), 32'd0);
        chk("arst_out",   32'(bus.word_out),   32'h00);
        chk("arst_cnt",   32'(bus.word_count), 32'd0);
        chk("arst_ovf",   32'(bus.overflow),   32'd0);
        #2;
        reset = 1'b1;
        send_bits(8'h4D, 0, 8);
        chk("post_arst_out",   32'(bus.word_out),   32'h4D);
        chk("post_arst_cnt",   32'(bus.word_count), 32'd1);
        chk("post_arst_valid", 32'(bus.word_valid), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
